// File: rtl/serial_adder.sv
// serial_adder: bit-serial add/subtract through one full-adder slice.
// One operand bit per clock, LSB first; done pulses when the result lands.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_nx;

    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] res;
    logic [CNT_W-1:0] cnt;
    logic             cin;
    logic             s;
    logic             co;
    logic             last;
    logic             accept;

    assign s    = opa[0] ^ opb[0] ^ cin;
    assign co   = (opa[0] & opb[0]) | (opa[0] & cin) | (opb[0] & cin);
    assign last = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        accept   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                done   = 1'b1;
                accept = start;
                if (start) begin
                    state_nx = RUN;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa      <= '0;
            opb      <= '0;
            res      <= '0;
            cnt      <= '0;
            cin      <= 1'b0;
            sum      <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
        end else if (accept) begin
            // subtraction as a + ~b + 1: invert b, seed carry with 1
            opa <= a;
            opb <= sub ? ~b : b;
            cin <= sub;
            cnt <= '0;
        end else if (state == RUN) begin
            opa <= opa >> 1;
            opb <= opb >> 1;
            cin <= co;
            cnt <= cnt + 1'b1;
            res <= {s, res[WIDTH-1:1]};
            if (last) begin
                // cin here is the carry into the MSB
                sum      <= {s, res[WIDTH-1:1]};
                carry    <= co;
                overflow <= cin ^ co;
            end
        end
    end

endmodule
